vend_txn_controller: RTL and testbench
======================================

VEND_TXN_CONTROLLER -- requirements
Module: vend_txn_controller

Interface
REQ-001 Parameter NUM_TYPES, default 8: number of item slots addressed by a 3-bit type.
REQ-002 Parameter STOCK_INIT, default 5: per-item stock loaded at reset.
REQ-003 Parameter STOCK_MAX, default 15: stock ceiling, 4-bit counter.
REQ-004 Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cust_req  in  1  customer purchase request, held until cust_ack.
REQ-008 cust_type  in  3  item type requested.
REQ-009 cust_qty  in  4  quantity requested.
REQ-010 cust_money  in  7  money inserted.
REQ-011 cust_ack  out  1  purchase complete; held high until cust_req falls.
REQ-012 op_req  in  1  operator restock request, held until op_ack.
REQ-013 op_type  in  3  item type to restock.
REQ-014 op_qty  in  4  units to add.
REQ-015 op_ack  out  1  restock complete; held high until op_req falls.
REQ-016 dispense_valid  out  1  one-cycle pulse on a successful purchase.
REQ-017 dispense_type  out  3 / dispense_qty  out  4  item and count dispensed, valid with dispense_valid.
REQ-018 change  out  7  money returned; registered, held until the next transaction commits.
REQ-019 error  out  7  error flags of the last transaction, held until the next commit.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, LOAD, CHECK, COMMIT, DONE.
- IDLE->LOAD when any request is high. LOAD->CHECK, CHECK->COMMIT and COMMIT->DONE are unconditional.
- DONE->IDLE when the granted request is low.
REQ-022 In IDLE, a 2-input round-robin arbiter picks the requester; the last-grant pointer resets to "customer", so the operator wins the first tie.
REQ-023 LOAD latches the granted request fields; later changes on the inputs have no effect until the next grant.
REQ-024 CHECK computes an 11-bit cost = PRICE[type] * qty and registers all error flags.
REQ-025 Error bits:
- [0] invalid type (PRICE = 0).
- [1] qty = 0.
- [2] customer qty > stock.
- [3] cost > money.
- [4] restock would exceed STOCK_MAX.
- [6:5] are always 0.
REQ-026 Bits [2] to [4] are evaluated only when type is valid; all applicable bits are set together.
REQ-027 COMMIT on a purchase with error == 0:
- stock[type] -= qty;
- dispense_valid pulses;
- change = money - cost (fits 7 bits).
REQ-028 COMMIT on a purchase with any error: stock is unchanged, no dispense, change = full money.
REQ-029 COMMIT on a restock with error == 0: stock[type] += qty, change = 0. On error, stock is unchanged.
REQ-030 In DONE, the matching ack is asserted; it deasserts in the cycle after the request falls.
REQ-031 Latency: ack rises on the 4th rising edge after the granted request is sampled in IDLE.
REQ-032 A request that arrives while busy waits and is served in a later IDLE; no request is ever dropped.

Reset
REQ-033 rst_n low asynchronously forces:
- state IDLE;
- every stock entry = STOCK_INIT;
- arbiter pointer = customer;
- all outputs 0.
REQ-034 Reset in any state, including mid-COMMIT, aborts the transaction: no ack, no dispense, stock reloaded.

Structure
REQ-035 Package vend_pkg holds:
- the price table: types 0 to 5 = 5, 10, 3, 7, 12, 2; types 6 and 7 = 0 (invalid);
- the error bit indices;
- the state enum;
- the widths (money 7, qty 4, type 3, cost 11).
REQ-036 The 2-requester round-robin arbiter is one sub-module, vend_rr_arb2.

Verification
REQ-037 Purchase: after reset, cust type 0, qty 2, money 20 -> dispense_valid pulse, qty 2, change 10, error 0, cust_ack on the 4th edge; stock[0] = 3.
REQ-038 Insufficient money and invalid type:
- cust type 5, qty 4, money 1 -> error 7'b0001000, change 1, no dispense.
- cust type 6, qty 3, money 15 -> error 7'b0000001, change 15.
REQ-039 Stock limits:
- cust type 2, qty 6, money 127 -> error bit [2] set, no dispense.
- op type 0, qty 12 with stock[0] = 5 -> error bit [4] set, stock unchanged.
- op type 0, qty 10 -> stock[0] = 15, error 0.
REQ-040 Arbitration: cust_req and op_req rise together after reset -> op served first, then cust. A second tie is served in alternating order.
REQ-041 Reset mid-transaction and hold: rst_n low during COMMIT -> outputs 0, no ack, stock = 5 everywhere. A request held high after DONE keeps ack high and starts no new transaction.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types, widths, error bit positions and price table for the vending controller.
package vend_pkg;

  localparam int unsigned TYPE_W  = 3;
  localparam int unsigned QTY_W   = 4;
  localparam int unsigned MONEY_W = 7;
  localparam int unsigned COST_W  = 11;
  localparam int unsigned ERR_W   = 7;

  localparam int unsigned ERR_BAD_TYPE = 0;
  localparam int unsigned ERR_ZERO_QTY = 1;
  localparam int unsigned ERR_NO_STOCK = 2;
  localparam int unsigned ERR_NO_MONEY = 3;
  localparam int unsigned ERR_OVERFLOW = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Unit price per item type; zero marks a type that cannot be sold or stocked.
  function automatic logic [3:0] price_of(input logic [TYPE_W-1:0] t);
    case (t)
      3'd0:    price_of = 4'd5;
      3'd1:    price_of = 4'd10;
      3'd2:    price_of = 4'd3;
      3'd3:    price_of = 4'd7;
      3'd4:    price_of = 4'd12;
      3'd5:    price_of = 4'd2;
      default: price_of = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_rr_arb2.sv
// Two-requester round-robin arbiter: bit 0 = customer, bit 1 = operator.
module vend_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_op_q, last_op_d;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_op_q ? 2'b01 : 2'b10;
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_comb begin
    last_op_d = last_op_q;
    if (advance && (|req)) begin
      last_op_d = gnt[1];
    end
  end

  // Pointer register; reset value means "customer was last", so operator wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_op_q <= 1'b0;
    end else begin
      last_op_q <= last_op_d;
    end
  end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction controller: arbitrates purchase/restock requests and updates stock.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int unsigned NUM_TYPES  = 8,
  parameter int unsigned STOCK_INIT = 5,
  parameter int unsigned STOCK_MAX  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cust_req,
  input  logic [TYPE_W-1:0]  cust_type,
  input  logic [QTY_W-1:0]   cust_qty,
  input  logic [MONEY_W-1:0] cust_money,
  output logic               cust_ack,
  input  logic               op_req,
  input  logic [TYPE_W-1:0]  op_type,
  input  logic [QTY_W-1:0]   op_qty,
  output logic               op_ack,
  output logic               dispense_valid,
  output logic [TYPE_W-1:0]  dispense_type,
  output logic [QTY_W-1:0]   dispense_qty,
  output logic [MONEY_W-1:0] change,
  output logic [ERR_W-1:0]   error,
  output logic               busy
);

  localparam logic [QTY_W-1:0] STOCK_INIT_V = QTY_W'(STOCK_INIT);
  localparam logic [QTY_W:0]   STOCK_MAX_V  = (QTY_W + 1)'(STOCK_MAX);

  state_e               state_q, state_d;
  logic                 is_op_q, is_op_d;
  logic [TYPE_W-1:0]    type_q, type_d;
  logic [QTY_W-1:0]     qty_q, qty_d;
  logic [MONEY_W-1:0]   money_q, money_d;
  logic [MONEY_W-1:0]   cost_lo_q, cost_lo_d;
  logic [ERR_W-1:0]     chk_err_q, chk_err_d;
  logic [QTY_W-1:0]     stock_q [NUM_TYPES];
  logic [QTY_W-1:0]     stock_d [NUM_TYPES];
  logic                 cust_ack_q, cust_ack_d;
  logic                 op_ack_q, op_ack_d;
  logic                 disp_valid_q, disp_valid_d;
  logic [TYPE_W-1:0]    disp_type_q, disp_type_d;
  logic [QTY_W-1:0]     disp_qty_q, disp_qty_d;
  logic [MONEY_W-1:0]   change_q, change_d;
  logic [ERR_W-1:0]     error_q, error_d;

  logic [1:0]           arb_gnt;
  logic [3:0]           price_w;
  logic [COST_W-1:0]    cost_w;
  logic [QTY_W-1:0]     stock_sel;
  logic [QTY_W:0]       restock_sum;
  logic                 type_ok;
  logic                 granted_req;

  vend_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({op_req, cust_req}),
    .advance (state_q == ST_IDLE),
    .gnt     (arb_gnt)
  );

  // Cost and limit arithmetic on the latched request, consumed in CHECK.
  always_comb begin
    price_w     = price_of(type_q);
    cost_w      = COST_W'(price_w) * COST_W'(qty_q);
    stock_sel   = stock_q[type_q];
    restock_sum = {1'b0, stock_sel} + {1'b0, qty_q};
    type_ok     = (price_w != 4'd0);
    granted_req = is_op_q ? op_req : cust_req;
  end

  // Transaction sequencing, error evaluation and commit of stock/outputs.
  always_comb begin
    state_d      = state_q;
    is_op_d      = is_op_q;
    type_d       = type_q;
    qty_d        = qty_q;
    money_d      = money_q;
    cost_lo_d    = cost_lo_q;
    chk_err_d    = chk_err_q;
    stock_d      = stock_q;
    cust_ack_d   = cust_ack_q;
    op_ack_d     = op_ack_q;
    disp_valid_d = 1'b0;
    disp_type_d  = disp_type_q;
    disp_qty_d   = disp_qty_q;
    change_d     = change_q;
    error_d      = error_q;
    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          is_op_d = arb_gnt[1];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        type_d  = is_op_q ? op_type : cust_type;
        qty_d   = is_op_q ? op_qty  : cust_qty;
        money_d = is_op_q ? '0      : cust_money;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // Only the low bits are kept: change is computed solely when cost <= money.
        cost_lo_d = cost_w[MONEY_W-1:0];
        chk_err_d = '0;
        chk_err_d[ERR_BAD_TYPE] = !type_ok;
        chk_err_d[ERR_ZERO_QTY] = (qty_q == '0);
        chk_err_d[ERR_NO_STOCK] = type_ok && !is_op_q && (qty_q > stock_sel);
        chk_err_d[ERR_NO_MONEY] = type_ok && !is_op_q && (cost_w > COST_W'(money_q));
        chk_err_d[ERR_OVERFLOW] = type_ok &&  is_op_q && (restock_sum > STOCK_MAX_V);
        state_d   = ST_COMMIT;
      end
      ST_COMMIT: begin
        error_d = chk_err_q;
        if (is_op_q) begin
          change_d = '0;
          op_ack_d = 1'b1;
          if (chk_err_q == '0) begin
            stock_d[type_q] = restock_sum[QTY_W-1:0];
          end
        end else begin
          cust_ack_d = 1'b1;
          if (chk_err_q == '0) begin
            stock_d[type_q] = stock_sel - qty_q;
            disp_valid_d    = 1'b1;
            disp_type_d     = type_q;
            disp_qty_d      = qty_q;
            change_d        = money_q - cost_lo_q;
          end else begin
            change_d = money_q;
          end
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!granted_req) begin
          cust_ack_d = 1'b0;
          op_ack_d   = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      is_op_q      <= 1'b0;
      type_q       <= '0;
      qty_q        <= '0;
      money_q      <= '0;
      cost_lo_q    <= '0;
      chk_err_q    <= '0;
      for (int unsigned i = 0; i < NUM_TYPES; i++) begin
        stock_q[i] <= STOCK_INIT_V;
      end
      cust_ack_q   <= 1'b0;
      op_ack_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_type_q  <= '0;
      disp_qty_q   <= '0;
      change_q     <= '0;
      error_q      <= '0;
    end else begin
      state_q      <= state_d;
      is_op_q      <= is_op_d;
      type_q       <= type_d;
      qty_q        <= qty_d;
      money_q      <= money_d;
      cost_lo_q    <= cost_lo_d;
      chk_err_q    <= chk_err_d;
      stock_q      <= stock_d;
      cust_ack_q   <= cust_ack_d;
      op_ack_q     <= op_ack_d;
      disp_valid_q <= disp_valid_d;
      disp_type_q  <= disp_type_d;
      disp_qty_q   <= disp_qty_d;
      change_q     <= change_d;
      error_q      <= error_d;
    end
  end

  assign cust_ack       = cust_ack_q;
  assign op_ack         = op_ack_q;
  assign dispense_valid = disp_valid_q;
  assign dispense_type  = disp_type_q;
  assign dispense_qty   = disp_qty_q;
  assign change         = change_q;
  assign error          = error_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench for vend_txn_controller: vector tables plus arbitration/reset/hold sequences.
module tb_vend_txn_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cust_req = 1'b0;
  logic [2:0] cust_type = '0;
  logic [3:0] cust_qty = '0;
  logic [6:0] cust_money = '0;
  logic       cust_ack;
  logic       op_req = 1'b0;
  logic [2:0] op_type = '0;
  logic [3:0] op_qty = '0;
  logic       op_ack;
  logic       dispense_valid;
  logic [2:0] dispense_type;
  logic [3:0] dispense_qty;
  logic [6:0] change;
  logic [6:0] error;
  logic       busy;

  always #5 clk = ~clk;

  vend_txn_controller #(.NUM_TYPES(8), .STOCK_INIT(5), .STOCK_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .cust_req(cust_req), .cust_type(cust_type), .cust_qty(cust_qty),
    .cust_money(cust_money), .cust_ack(cust_ack),
    .op_req(op_req), .op_type(op_type), .op_qty(op_qty), .op_ack(op_ack),
    .dispense_valid(dispense_valid), .dispense_type(dispense_type),
    .dispense_qty(dispense_qty), .change(change), .error(error), .busy(busy)
  );

  typedef struct {
    bit         op;
    logic [2:0] t;
    logic [3:0] q;
    logic [6:0] m;
    logic [6:0] err;
    logic [6:0] chg;
  } vec_t;

  typedef struct {
    bit         op;
    logic [6:0] err;
    logic [6:0] chg;
    bit         disp;
    logic [2:0] t;
    logic [3:0] q;
    logic [3:0] stock;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] model [8];
  bit         disp_seen = 1'b0;
  logic [2:0] disp_t;
  logic [3:0] disp_q;
  bit         prev_c = 1'b0;
  bit         prev_o = 1'b0;
  vec_t       va [13];
  vec_t       vb [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit op, input int t, input int q, input int m,
                              input int err, input int chg);
    vec_t v;
    v.op = op; v.t = 3'(t); v.q = 4'(q); v.m = 7'(m); v.err = 7'(err); v.chg = 7'(chg);
    return v;
  endfunction

  // Expected outcome in service order; the stock model advances only on error-free commits.
  task automatic push_exp(input vec_t v);
    exp_t e;
    e.op = v.op; e.err = v.err; e.chg = v.chg; e.t = v.t; e.q = v.q;
    e.disp = !v.op && (v.err == 7'd0);
    if (v.err == 7'd0) model[v.t] = v.op ? model[v.t] + v.q : model[v.t] - v.q;
    e.stock = model[v.t];
    sb.push_back(e);
  endtask

  task automatic set_req(input vec_t v);
    if (v.op) begin
      op_type = v.t; op_qty = v.q; op_req = 1'b1;
    end else begin
      cust_type = v.t; cust_qty = v.q; cust_money = v.m; cust_req = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit op, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(op ? op_ack : cust_ack) && n < 40);
    if (!(op ? op_ack : cust_ack)) chk("ack_timeout", 0, 1);
  endtask

  task automatic release_req(input bit op);
    @(negedge clk);
    if (op) op_req = 1'b0; else cust_req = 1'b0;
    @(posedge clk); #1;
    chk("ack_release", op ? int'(op_ack) : int'(cust_ack), 0);
    chk("idle_after_release", int'(busy), 0);
  endtask

  task automatic txn(input vec_t v);
    int n;
    push_exp(v);
    @(negedge clk);
    set_req(v);
    wait_ack(v.op, n);
    chk("ack_latency", n, 4);
    release_req(v.op);
  endtask

  // Both requests rise on the same edge; 'first' is the one the arbiter must pick.
  task automatic tie(input vec_t first, input vec_t second);
    int n;
    push_exp(first);
    push_exp(second);
    @(negedge clk);
    set_req(first);
    set_req(second);
    wait_ack(first.op, n);
    chk("tie_first_latency", n, 4);
    chk("tie_other_waits", second.op ? int'(op_ack) : int'(cust_ack), 0);
    @(negedge clk);
    if (first.op) op_req = 1'b0; else cust_req = 1'b0;
    wait_ack(second.op, n);
    chk("tie_second_latency", n, 5);
    release_req(second.op);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cust_req = 1'b0;
    op_req = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 4'd5;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    disp_seen = 1'b0;
  endtask

  // Scoreboard consumer: one expectation popped per rising ack.
  task automatic monitor_step();
    exp_t e;
    if (dispense_valid) begin
      disp_seen = 1'b1; disp_t = dispense_type; disp_q = dispense_qty;
    end
    if ((cust_ack && !prev_c) || (op_ack && !prev_o)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("ack_is_op", int'(op_ack && !prev_o), int'(e.op));
        chk("error", int'(error), int'(e.err));
        chk("change", int'(change), int'(e.chg));
        chk("dispensed", int'(disp_seen), int'(e.disp));
        if (e.disp) begin
          chk("dispense_type", int'(disp_t), int'(e.t));
          chk("dispense_qty", int'(disp_q), int'(e.q));
        end
        chk("stock", int'(dut.stock_q[e.t]), int'(e.stock));
      end
      disp_seen = 1'b0;
    end
    prev_c = cust_ack;
    prev_o = op_ack;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++) model[i] = 4'd5;

    va[0]  = mk(0, 0, 2, 20,  7'h00, 10);
    va[1]  = mk(0, 5, 4, 1,   7'h08, 1);
    va[2]  = mk(0, 6, 3, 15,  7'h01, 15);
    va[3]  = mk(0, 2, 6, 127, 7'h04, 127);
    va[4]  = mk(0, 1, 0, 5,   7'h02, 5);
    va[5]  = mk(0, 7, 0, 9,   7'h03, 9);
    va[6]  = mk(0, 3, 2, 14,  7'h00, 0);
    va[7]  = mk(0, 4, 5, 60,  7'h00, 0);
    va[8]  = mk(0, 4, 1, 127, 7'h04, 127);
    va[9]  = mk(1, 4, 15, 0,  7'h00, 0);
    va[10] = mk(1, 4, 1, 0,   7'h10, 0);
    va[11] = mk(1, 2, 0, 0,   7'h02, 0);
    va[12] = mk(0, 1, 6, 5,   7'h0C, 5);

    vb[0]  = mk(1, 0, 12, 0,  7'h10, 0);
    vb[1]  = mk(1, 0, 10, 0,  7'h00, 0);
    vb[2]  = mk(1, 6, 3, 0,   7'h01, 0);
    vb[3]  = mk(0, 0, 15, 127, 7'h00, 52);

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_cust_ack", int'(cust_ack), 0);
    chk("reset_op_ack", int'(op_ack), 0);
    chk("reset_dispense", int'(dispense_valid), 0);
    chk("reset_change", int'(change), 0);
    chk("reset_error", int'(error), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (va[i]) txn(va[i]);

    do_reset();
    foreach (vb[i]) txn(vb[i]);

    // Reset landing in COMMIT must abort the purchase entirely.
    @(negedge clk);
    set_req(mk(0, 1, 1, 10, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_cust_ack", int'(cust_ack), 0);
    chk("abort_dispense", int'(dispense_valid), 0);
    chk("abort_disp_type", int'(dispense_type), 0);
    chk("abort_disp_qty", int'(dispense_qty), 0);
    chk("abort_change", int'(change), 0);
    chk("abort_error", int'(error), 0);
    for (int i = 0; i < 8; i++) chk("abort_stock", int'(dut.stock_q[i]), 5);
    cust_req = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 4'd5;
    repeat (2) @(negedge clk);
    chk("abort_no_dispense_seen", int'(disp_seen), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_late_ack", int'(cust_ack), 0);

    // Request held past DONE: ack stays up, nothing new starts.
    push_exp(mk(0, 0, 1, 5, 7'h00, 0));
    @(negedge clk);
    set_req(mk(0, 0, 1, 5, 0, 0));
    wait_ack(1'b0, n);
    chk("hold_latency", n, 4);
    repeat (8) begin
      @(posedge clk); #1;
      chk("hold_ack_high", int'(cust_ack), 1);
    end
    chk("hold_no_redispense", int'(disp_seen), 0);
    chk("hold_stock", int'(dut.stock_q[0]), 4);
    release_req(1'b0);

    do_reset();
    tie(mk(1, 1, 2, 0, 7'h00, 0), mk(0, 1, 3, 30, 7'h00, 0));
    tie(mk(1, 3, 4, 0, 7'h00, 0), mk(0, 3, 9, 127, 7'h00, 64));
    txn(mk(1, 5, 10, 0, 7'h00, 0));
    tie(mk(0, 5, 15, 30, 7'h00, 0), mk(1, 5, 15, 0, 7'h00, 0));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
